instr_fetch: RTL and testbench

Instruction fetch stage for the mini microcontroller. It owns the program counter and drives word-addressed reads into the synchronous instruction memory (1-cycle read latency). It buffers returned words in a 2-entry queue and presents them to the decode/ALU stage over a valid/ready handshake, with the instruction fields pre-split. A redirect input (branch/jump) flushes all in-flight and buffered instructions and restarts fetch at a new address.

---
 rtl/instr_fetch.sv | 78 +++++++
 tb/tb_instr_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing 1-cycle-latency imem reads into a 2-entry queue
// that feeds decode over valid/ready, flushed and restarted by redirect.
module instr_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [4:0]            out_opcode,
    output logic [8:0]            out_rd,
    output logic [8:0]            out_rs1,
    output logic [8:0]            out_rs2
);
    logic [ADDR_WIDTH-1:0] pc, inflight_pc;
    logic                  inflight;
    logic [31:0]           instr_q [2];
    logic [ADDR_WIDTH-1:0] pc_q [2];
    logic                  rd_ptr, wr_ptr;
    logic [1:0]            count;
    logic                  deq;
    logic [2:0]            occ;

    assign out_valid = rst & (count != 2'd0) & ~redirect_valid;
    assign deq       = out_valid & out_ready;
    // queue slots committed after this edge: buffered + returning - leaving
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, deq};
    assign imem_en   = rst & ~redirect_valid & (occ < 3'd2);
    assign imem_addr = pc;
    assign out_instr = rst ? instr_q[rd_ptr] : '0;
    assign out_pc    = rst ? pc_q[rd_ptr] : '0;
    assign out_opcode = out_instr[31:27];
    assign out_rd     = out_instr[26:18];
    assign out_rs1    = out_instr[17:9];
    assign out_rs2    = out_instr[8:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            instr_q[0]  <= '0;
            instr_q[1]  <= '0;
            pc_q[0]     <= '0;
            pc_q[1]     <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                pc          <= pc + ADDR_WIDTH'(1);
                inflight_pc <= pc;
            end
            if (inflight) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= inflight_pc;
            end
            wr_ptr <= wr_ptr ^ inflight;
            rd_ptr <= rd_ptr ^ deq;
            count  <= count + {1'b0, inflight} - {1'b0, deq};
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios against a queue-level model of the fetch
// stage, plus a narrow-address instance for PC wrap.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        out_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
    logic [4:0]  out_opcode;
    logic [8:0]  out_rd, out_rs1, out_rs2;

    logic        w_redirect_valid = 1'b0;
    logic [3:0]  w_redirect_pc = '0;
    logic        w_imem_en, w_out_valid;
    logic [3:0]  w_imem_addr, w_out_pc;
    logic [31:0] w_imem_rdata, w_out_instr;
    logic [4:0]  w_out_opcode;
    logic [8:0]  w_out_rd, w_out_rs1, w_out_rs2;

    int checks = 0;
    int passed = 0;
    logic [31:0] log_q[$];
    logic [3:0]  wlog_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2));

    instr_fetch #(.ADDR_WIDTH(4), .RESET_PC(4'h0)) dut_w (
        .clk(clk), .rst(rst), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .redirect_valid(w_redirect_valid),
        .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_opcode(w_out_opcode),
        .out_rd(w_out_rd), .out_rs1(w_out_rs1), .out_rs2(w_out_rs2));

    function automatic logic [31:0] word(input logic [31:0] k);
        return {5'(k % 19), 9'(k), 9'(k + 1), 9'(k + 2)};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word(imem_addr);
        if (w_imem_en) w_imem_rdata <= word({28'b0, w_imem_addr});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // delivery logs: valid&ready at the negedge means the word leaves at the next edge
    always @(negedge clk) begin
        if (out_valid && out_ready) log_q.push_back(out_pc);
        if (w_out_valid) wlog_q.push_back(w_out_pc);
    end

    // model: ready queue of fetched addresses, at most one pending read, next fetch PC
    logic [31:0] mq[$];
    bit          pend_v = 0;
    logic [31:0] pend_a = '0;
    logic [31:0] npc = '0;

    always @(negedge clk) begin
        bit ev, een, edq;
        logic [31:0] k;
        ev  = rst && mq.size() != 0 && !redirect_valid;
        edq = ev && out_ready;
        een = rst && !redirect_valid && (mq.size() + int'(pend_v) - int'(edq)) < 2;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("imem_en", 64'(imem_en), 64'(een));
        if (rst) chk("imem_addr", 64'(imem_addr), 64'(npc));
        else begin
            chk("rst_instr", 64'(out_instr), 64'd0);
            chk("rst_pc", 64'(out_pc), 64'd0);
        end
        if (ev) begin
            k = mq[0];
            chk("out_pc", 64'(out_pc), 64'(k));
            chk("out_instr", 64'(out_instr), 64'(word(k)));
            chk("out_opcode", 64'(out_opcode), 64'(k % 19));
            chk("out_rd", 64'(out_rd), 64'(k & 32'h1ff));
            chk("out_rs1", 64'(out_rs1), 64'((k + 1) & 32'h1ff));
            chk("out_rs2", 64'(out_rs2), 64'((k + 2) & 32'h1ff));
        end
        if (!rst) begin
            mq.delete();
            pend_v = 0;
            npc = 32'h0;
        end else if (redirect_valid) begin
            mq.delete();
            pend_v = 0;
            npc = redirect_pc;
        end else begin
            if (edq) void'(mq.pop_front());
            if (pend_v) mq.push_back(pend_a);
            pend_v = een;
            if (een) begin
                pend_a = npc;
                npc = npc + 1;
            end
        end
    end

    initial begin
        int n, bad;
        repeat (3) step();
        // power-up: first valid two cycles after release
        rst = 1'b1;
        log_q.delete();
        #1;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("first_valid_lat", 64'(n), 64'd2);
        chk("first_pc", 64'(out_pc), 64'd0);
        repeat (6) step();
        out_ready = 1'b0;
        repeat (5) step();
        #1;
        chk("stall_en", 64'(imem_en), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (6) step();
        bad = 0;
        foreach (log_q[i]) if (log_q[i] != 32'(i)) bad++;
        chk("stream_contig", 64'(bad), 64'd0);
        chk("stream_len", 64'(log_q.size() >= 10), 64'd1);
        // reset mid-stream
        step();
        rst = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_en", 64'(imem_en), 64'd0);
        chk("mrst_instr", 64'(out_instr), 64'd0);
        chk("mrst_pc", 64'(out_pc), 64'd0);
        chk("mrst_opcode", 64'(out_opcode), 64'd0);
        step();
        rst = 1'b1;
        log_q.delete();
        #1;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("restart_lat", 64'(n), 64'd2);
        chk("restart_pc", 64'(out_pc), 64'd0);
        // redirect while PC 3 heads the queue and PC 4 is in flight
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("redir_valid", 64'(out_valid), 64'd0);
        chk("redir_en", 64'(imem_en), 64'd0);
        chk("redir_head_pc", 64'(out_pc), 64'd3);
        chk("redir_head_instr", 64'(out_instr), 64'h180C0805);
        step();
        redirect_valid = 1'b0;
        n = 1;
        #1;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("redir_lat", 64'(n), 64'd3);
        chk("redir_first_pc", 64'(out_pc), 64'h40);
        repeat (4) step();
        chk("redir_log0", 64'(log_q[0]), 64'd0);
        chk("redir_log2", 64'(log_q[2]), 64'd2);
        chk("redir_log3", 64'(log_q[3]), 64'h40);
        chk("redir_log4", 64'(log_q[4]), 64'h41);
        bad = 0;
        foreach (log_q[i]) if (log_q[i] == 32'd3 || log_q[i] == 32'd4) bad++;
        chk("redir_flushed", 64'(bad), 64'd0);
        // back-to-back redirects with the queue full
        step();
        out_ready = 1'b0;
        log_q.delete();
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("b2b_log0", 64'(log_q[0]), 64'h20);
        chk("b2b_log1", 64'(log_q[1]), 64'h21);
        chk("b2b_len", 64'(log_q.size() >= 4), 64'd1);
        bad = 0;
        foreach (log_q[i]) if (log_q[i] < 32'h20) bad++;
        chk("b2b_no_stale", 64'(bad), 64'd0);
        // 4-bit PC wraps from 0xF to 0x0
        w_redirect_valid = 1'b1;
        w_redirect_pc = 4'hE;
        wlog_q.delete();
        step();
        w_redirect_valid = 1'b0;
        repeat (8) step();
        chk("wrap0", 64'(wlog_q[0]), 64'hE);
        chk("wrap1", 64'(wlog_q[1]), 64'hF);
        chk("wrap2", 64'(wlog_q[2]), 64'h0);
        chk("wrap3", 64'(wlog_q[3]), 64'h1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
